// File: rtl/tetris_pkg.sv
// Shared definitions for the game input path: key indices, default timings at 25 MHz,
// and the auto-repeat state encoding.
package tetris_pkg;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  localparam int DEF_DEBOUNCE_CYCLES     = 250_000;   // 10 ms
  localparam int DEF_REPEAT_DELAY_CYCLES = 6_250_000; // 250 ms
  localparam int DEF_REPEAT_RATE_CYCLES  = 1_250_000; // 50 ms

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/key_conditioner_if.sv
// Key bus between the board buttons and the game logic; the conditioner is the slave side.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] keys_raw;
  logic [N_KEYS-1:0] keys_level;
  logic [N_KEYS-1:0] keys_press;
  logic [N_KEYS-1:0] keys_release;
  logic              any_pressed;

  modport master (output keys_raw, input keys_level, keys_press, keys_release, any_pressed);
  modport slave  (input keys_raw, output keys_level, keys_press, keys_release, any_pressed);
endinterface

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, counter debouncer, press/release pulses and
// delayed-auto-shift repeat.
module key_channel
  import tetris_pkg::*;
#(
  parameter bit KEY_ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter bit REPEAT_EN           = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int TW   = $clog2(RMAX + 1);

  logic [1:0]    sync_pipe;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] dcnt;
  logic          accept, rise, fall;

  rpt_state_e    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          press_n, rel_n;

  assign sync2  = sync_pipe[1];
  assign accept = (sync2 != stable) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise   = accept &  sync2;
  assign fall   = accept & ~sync2;
  assign level  = stable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pipe <= '0;
      stable    <= 1'b0;
      dcnt      <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw ^ KEY_ACTIVE_LOW};
      if (sync2 == stable) begin
        dcnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      press <= press_n;
      rel   <= rel_n;
    end
  end

  // A release always beats a repeat tick landing on the same cycle.
  always_comb begin
    state_n = state;
    timer_n = timer;
    press_n = 1'b0;
    rel_n   = 1'b0;
    if (fall) begin
      state_n = IDLE;
      timer_n = '0;
      rel_n   = 1'b1;
    end else begin
      case (state)
        IDLE: if (rise) begin
          press_n = 1'b1;
          if (REPEAT_EN) begin
            state_n = DELAY;
            timer_n = '0;
          end
        end
        DELAY: if (timer == TW'(REPEAT_DELAY_CYCLES - 1)) begin
          press_n = 1'b1;
          timer_n = '0;
          state_n = RPT;
        end else begin
          timer_n = timer + 1'b1;
        end
        RPT: if (timer == TW'(REPEAT_RATE_CYCLES - 1)) begin
          press_n = 1'b1;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw board buttons into clean levels and press/release/repeat
// pulses in the vga_clk domain.
module key_conditioner
  import tetris_pkg::*;
#(
  parameter int N_KEYS              = 4,
  parameter bit KEY_ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter     REPEAT_MASK         = 4'b1110
) (
  input  logic          vga_clk,
  input  logic          rst,
  key_conditioner_if.slave kif
);
  localparam logic [N_KEYS-1:0] RPT_EN = N_KEYS'(REPEAT_MASK);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cycles
    $error("key_conditioner: *_CYCLES parameters must be >= 1");
  end
  if ($bits(REPEAT_MASK) > N_KEYS) begin : g_bad_mask
    $error("key_conditioner: REPEAT_MASK wider than N_KEYS");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_channel #(
      .KEY_ACTIVE_LOW     (KEY_ACTIVE_LOW),
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .REPEAT_EN          (RPT_EN[i])
    ) u_ch (
      .clk  (vga_clk),
      .rst  (rst),
      .raw  (kif.keys_raw[i]),
      .level(kif.keys_level[i]),
      .press(kif.keys_press[i]),
      .rel  (kif.keys_release[i])
    );
  end

  assign kif.any_pressed = |kif.keys_level;
endmodule
